// File: rtl/nic8_pkg.sv
// Shared loader types: FSM state encoding and length decode.
// Imported by the program loader and its sub-blocks.
package nic8_pkg;

  typedef enum logic [2:0] {
    WAIT_LEN,
    LOAD,
    CHECK,
    RUN,
    FAIL
  } loader_state_t;

  // A length byte of zero selects a full 256-byte image.
  localparam logic [8:0] LOADER_MAX_LEN = 9'd256;

  function automatic logic [8:0] len_to_count(
    input logic [7:0] n
  );
    if (n == 8'h00) begin
      return LOADER_MAX_LEN;
    end
    return {1'b0, n};
  endfunction

endpackage

// File: rtl/byte_sum.sv
// 8-bit modulo-256 running sum with clear and add enable.
// Ports: clk, rst_n, clr_i, add_i, data_i[7:0] -> sum_o[7:0].
module byte_sum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       add_i,
  input  logic [7:0] data_i,
  output logic [7:0] sum_o
);

  logic [7:0] sum_q;
  logic [7:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = 8'h00;
    end else if (add_i) begin
      sum_d = sum_q + data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/prog_loader.sv
// Boot loader: length, data bytes, checksum -> program memory writes,
// then releases CPU reset on a matching checksum.
// Ports: clk, resetBar, in_valid/in_data/in_ready (host byte stream),
// mem_we/mem_addr/mem_wdata (memory write), cpu_resetBar, done, error.
module prog_loader
  import nic8_pkg::*;
#(
  parameter logic [7:0] START_ADDR = 8'h00
) (
  input  logic       clk,
  input  logic       resetBar,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_resetBar,
  output logic       done,
  output logic       error
);

  loader_state_t state_q, state_d;
  logic [8:0]    cnt_q, cnt_d;
  logic [7:0]    addr_q, addr_d;
  logic          we_q, we_d;
  logic [7:0]    waddr_q, waddr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          sum_clr;
  logic          sum_add;
  logic [7:0]    sum;
  logic          xfer;

  assign in_ready = (state_q == WAIT_LEN)
                  | (state_q == LOAD)
                  | (state_q == CHECK);
  assign xfer = in_valid & in_ready;

  byte_sum u_sum (
    .clk    (clk),
    .rst_n  (resetBar),
    .clr_i  (sum_clr),
    .add_i  (sum_add),
    .data_i (in_data),
    .sum_o  (sum)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    sum_clr = 1'b0;
    sum_add = 1'b0;
    unique case (state_q)
      WAIT_LEN: begin
        if (xfer) begin
          state_d = LOAD;
          cnt_d   = len_to_count(in_data);
          addr_d  = START_ADDR;
          sum_clr = 1'b1;
        end
      end
      LOAD: begin
        if (xfer) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = in_data;
          addr_d  = addr_q + 8'd1;
          cnt_d   = cnt_q - 9'd1;
          sum_add = 1'b1;
          if (cnt_q == 9'd1) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (xfer) begin
          state_d = (in_data == sum) ? RUN : FAIL;
        end
      end
      default: begin
      end
    endcase
  end

  // Write strobe is registered so an async reset also
  // cancels a write pending from the last accepted byte.
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      state_q <= WAIT_LEN;
      cnt_q   <= 9'd0;
      addr_q  <= START_ADDR;
      we_q    <= 1'b0;
      waddr_q <= START_ADDR;
      wdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_we       = we_q;
  assign mem_addr     = waddr_q;
  assign mem_wdata    = wdata_q;
  assign cpu_resetBar = (state_q == RUN);
  assign done         = (state_q == RUN);
  assign error        = (state_q == FAIL);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader.
// Captures memory writes and checks them against hand-computed streams.
module tb_prog_loader;

  logic       clk;
  logic       resetBar;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_resetBar;
  logic       done;
  logic       error;

  int n_chk;
  int n_fail;

  logic [7:0] wa[$];
  logic [7:0] wd[$];

  prog_loader #(.START_ADDR(8'h00)) dut (
    .clk          (clk),
    .resetBar     (resetBar),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_resetBar (cpu_resetBar),
    .done         (done),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mem_we is a one-cycle pulse, so one negedge sees each write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    int k;
    k = 0;
    while ($urandom_range(1) == 1 && k < 6) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk);
      k++;
    end
    send(b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetBar = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    resetBar = 1'b1;
    wa.delete();
    wd.delete();
  endtask

  task automatic test_reset();
    resetBar = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #2;
    n_chk++;
    if ({mem_we, cpu_resetBar, done, error} !== 4'b0000) begin
      $display("FAIL rst_flags got %b want 0000",
               {mem_we, cpu_resetBar, done, error});
      n_fail++;
    end
    n_chk++;
    if (mem_wdata !== 8'h00) begin
      $display("FAIL rst_wdata got %h want 00", mem_wdata);
      n_fail++;
    end
    n_chk++;
    if (in_ready !== 1'b1) begin
      $display("FAIL rst_ready got %b want 1", in_ready);
      n_fail++;
    end
    @(negedge clk);
    resetBar = 1'b1;
    #1;
    n_chk++;
    if ({in_ready, mem_we, done, error} !== 4'b1000) begin
      $display("FAIL rst_release got %b want 1000",
               {in_ready, mem_we, done, error});
      n_fail++;
    end
  endtask

  task automatic test_good();
    do_reset();
    send(8'h03);
    send(8'h11);
    n_chk++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h00, 8'h11}) begin
      $display("FAIL good_latency got %b/%h/%h want 1/00/11",
               mem_we, mem_addr, mem_wdata);
      n_fail++;
    end
    send(8'h22);
    send(8'h33);
    send(8'h66);
    idle(2);
    n_chk++;
    if (wa.size() !== 3) begin
      $display("FAIL good_nwr got %0d want 3", wa.size());
      n_fail++;
    end
    n_chk++;
    if ({wa[0], wd[0], wa[1], wd[1], wa[2], wd[2]}
        !== 48'h00_11_01_22_02_33) begin
      $display("FAIL good_wr got %h:%h %h:%h %h:%h want 00:11 01:22 02:33",
               wa[0], wd[0], wa[1], wd[1], wa[2], wd[2]);
      n_fail++;
    end
    n_chk++;
    if ({done, cpu_resetBar, in_ready, error} !== 4'b1100) begin
      $display("FAIL good_end got %b want 1100",
               {done, cpu_resetBar, in_ready, error});
      n_fail++;
    end
  endtask

  task automatic test_after_done();
    send(8'h05);
    send(8'h77);
    send(8'h88);
    idle(2);
    n_chk++;
    if (wa.size() !== 3) begin
      $display("FAIL extra_nwr got %0d want 3", wa.size());
      n_fail++;
    end
    n_chk++;
    if ({done, cpu_resetBar, in_ready, error} !== 4'b1100) begin
      $display("FAIL extra_state got %b want 1100",
               {done, cpu_resetBar, in_ready, error});
      n_fail++;
    end
  endtask

  task automatic test_bad_sum();
    do_reset();
    send(8'h02);
    send(8'h10);
    send(8'h20);
    send(8'h31);
    idle(2);
    n_chk++;
    if ({wa.size() == 2, wa[0], wd[0], wa[1], wd[1]}
        !== {1'b1, 32'h00_10_01_20}) begin
      $display("FAIL bad_wr got n=%0d %h:%h %h:%h want 00:10 01:20",
               wa.size(), wa[0], wd[0], wa[1], wd[1]);
      n_fail++;
    end
    n_chk++;
    if ({error, cpu_resetBar, in_ready, done} !== 4'b1000) begin
      $display("FAIL bad_end got %b want 1000",
               {error, cpu_resetBar, in_ready, done});
      n_fail++;
    end
    send(8'h01);
    idle(2);
    n_chk++;
    if ({error, wa.size() == 2} !== 2'b11) begin
      $display("FAIL bad_sticky got err=%b n=%0d want 1/2",
               error, wa.size());
      n_fail++;
    end
  endtask

  task automatic test_wrap();
    int bad;
    do_reset();
    send(8'h00);
    for (int i = 0; i < 256; i++) begin
      send(8'(i));
    end
    n_chk++;
    if ({in_ready, done, error} !== 3'b100) begin
      $display("FAIL wrap_precheck got %b want 100",
               {in_ready, done, error});
      n_fail++;
    end
    send(8'h80);
    idle(2);
    n_chk++;
    if (wa.size() !== 256) begin
      $display("FAIL wrap_nwr got %0d want 256", wa.size());
      n_fail++;
    end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (i < wa.size()) begin
        if (wa[i] !== 8'(i) || wd[i] !== 8'(i)) bad++;
      end
    end
    n_chk++;
    if (bad !== 0) begin
      $display("FAIL wrap_wr got %0d bad entries want 0", bad);
      n_fail++;
    end
    n_chk++;
    if ({done, cpu_resetBar, error} !== 3'b110) begin
      $display("FAIL wrap_end got %b want 110",
               {done, cpu_resetBar, error});
      n_fail++;
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    send(8'h04);
    send(8'hA1);
    send(8'hA2);
    resetBar = 1'b0;
    #1;
    n_chk++;
    if ({mem_we, in_ready, done, cpu_resetBar} !== 4'b0100) begin
      $display("FAIL midrst_now got %b want 0100",
               {mem_we, in_ready, done, cpu_resetBar});
      n_fail++;
    end
    @(negedge clk);
    @(negedge clk);
    resetBar = 1'b1;
    idle(3);
    n_chk++;
    if ({wa.size() == 1, wa[0], wd[0]} !== {1'b1, 16'h00_A1}) begin
      $display("FAIL midrst_wr got n=%0d %h:%h want 1 00:a1",
               wa.size(), wa[0], wd[0]);
      n_fail++;
    end
    wa.delete();
    wd.delete();
    send(8'h01);
    send(8'hAA);
    send(8'hAA);
    idle(2);
    n_chk++;
    if ({wa.size() == 1, wa[0], wd[0], done} !== {1'b1, 16'h00_AA, 1'b1}) begin
      $display("FAIL midrst_reload got n=%0d %h:%h done=%b want 00:aa 1",
               wa.size(), wa[0], wd[0], done);
      n_fail++;
    end
  endtask

  task automatic test_gaps();
    do_reset();
    send_gap(8'h03);
    send_gap(8'h01);
    send_gap(8'h02);
    send_gap(8'h03);
    send_gap(8'h06);
    idle(2);
    n_chk++;
    if ({wa.size() == 3, wa[0], wd[0], wa[1], wd[1], wa[2], wd[2]}
        !== {1'b1, 48'h00_01_01_02_02_03}) begin
      $display("FAIL gap_wr got n=%0d %h:%h %h:%h %h:%h",
               wa.size(), wa[0], wd[0], wa[1], wd[1], wa[2], wd[2]);
      n_fail++;
    end
    n_chk++;
    if ({done, cpu_resetBar, in_ready} !== 3'b110) begin
      $display("FAIL gap_end got %b want 110",
               {done, cpu_resetBar, in_ready});
      n_fail++;
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_good();
    test_after_done();
    test_bad_sum();
    test_wrap();
    test_mid_reset();
    test_gaps();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
